// File: rtl/conv_encoder_serial_if.sv
// Handshake and data bundle between a block source and the serial convolutional encoder.
interface conv_encoder_serial_if #(
  parameter int N_BITS = 192
);
  logic                  start;
  logic [N_BITS-1:0]     m_text;
  logic [2*N_BITS-1:0]   encoder;
  logic                  done;
  logic                  busy;

  modport master (output start, m_text, input encoder, done, busy);
  modport slave  (input start, m_text, output encoder, done, busy);
endinterface

// File: rtl/conv_encoder_serial.sv
// Rate-1/2, constraint-length-7 convolutional encoder that serialises one message bit per clock
// and publishes the whole code word at once when the block completes.
module conv_encoder_serial #(
  parameter int         N_BITS = 192,
  parameter logic [6:0] G0     = 7'o133,
  parameter logic [6:0] G1     = 7'o171
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_encoder_serial_if.slave bus
);

  localparam int CW = $clog2(N_BITS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [N_BITS-1:0]   msg;
  logic [5:0]          hist;
  logic [CW-1:0]       cnt;
  logic [2*N_BITS-1:0] cw_buf;
  logic [2*N_BITS-1:0] cw_next;
  logic [6:0]          win;
  logic                bit_a;
  logic                bit_b;

  function automatic logic tap_xor(input logic [6:0] g, input logic [6:0] w);
    return ^(g & w);
  endfunction

  // win[6] is the current bit, win[6-i] the bit i steps back; msg shifts right so msg[0] is current.
  always_comb begin
    win     = {msg[0], hist};
    bit_a   = tap_xor(G0, win);
    bit_b   = tap_xor(G1, win);
    cw_next = {bit_a, bit_b, cw_buf[2*N_BITS-1:2]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      msg         <= '0;
      hist        <= '0;
      cnt         <= '0;
      cw_buf      <= '0;
      bus.encoder <= '0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            msg      <= bus.m_text;
            hist     <= '0;
            cnt      <= '0;
            cw_buf   <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          msg    <= msg >> 1;
          hist   <= {win[6], hist[5:1]};
          cw_buf <= cw_next;
          // Pairs enter at the top and shift down, so after N_BITS steps pair k sits at [2k+1:2k].
          if (cnt == CW'(N_BITS - 1)) begin
            bus.encoder <= cw_next;
            bus.done    <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_serial.sv
// Self-checking bench for conv_encoder_serial: timeline model plus reference encoder and Viterbi decoder.
module tb_conv_encoder_serial;

  localparam int         N  = 192;
  localparam int         W  = 2 * N;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  conv_encoder_serial_if #(.N_BITS(N)) bus ();

  conv_encoder_serial #(.N_BITS(N), .G0(G0), .G1(G1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct evaluation of the code equations: A[k] = XOR_i G0[6-i]&x[k-i], x[j<0]=0.
  function automatic logic [W-1:0] ref_encode(input logic [N-1:0] x);
    logic [W-1:0] c;
    logic a, b;
    c = '0;
    for (int k = 0; k < N; k++) begin
      a = 1'b0;
      b = 1'b0;
      for (int i = 0; i <= 6; i++) begin
        if (k - i >= 0) begin
          a = a ^ (G0[6-i] & x[k-i]);
          b = b ^ (G1[6-i] & x[k-i]);
        end
      end
      c[2*k+1] = a;
      c[2*k]   = b;
    end
    return c;
  endfunction

  // Hard-decision Viterbi over 64 states, full-length survivors, best end state.
  function automatic logic [N-1:0] viterbi(input logic [W-1:0] cw);
    int          metric [64];
    int          nmet   [64];
    logic [N-1:0] path  [64];
    logic [N-1:0] npath [64];
    logic [5:0]  s, ns;
    logic [6:0]  w;
    int          m, bs;
    for (int i = 0; i < 64; i++) begin
      metric[i] = (i == 0) ? 0 : 100000;
      path[i]   = '0;
    end
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 64; j++) begin
        ns       = 6'(j);
        nmet[j]  = 1 << 30;
        npath[j] = '0;
        for (int p = 0; p < 2; p++) begin
          s = {ns[4:0], 1'(p)};
          w = {ns[5], s};
          m = metric[s] + (((^(G0 & w)) != cw[2*k+1]) ? 1 : 0)
                        + (((^(G1 & w)) != cw[2*k])   ? 1 : 0);
          if (m < nmet[j]) begin
            nmet[j]     = m;
            npath[j]    = path[s];
            npath[j][k] = ns[5];
          end
        end
      end
      metric = nmet;
      path   = npath;
    end
    bs = 0;
    for (int j = 1; j < 64; j++) if (metric[j] < metric[bs]) bs = j;
    return path[bs];
  endfunction

  function automatic logic [N-1:0] rnd_msg();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Timeline model: capture, N encode cycles, one done cycle, back to idle.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_enc  = '0;
  logic [N-1:0] m_msg  = '0;
  int           m_age  = -1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_enc  <= '0;
      m_age  <= -1;
    end else if (m_age < 0) begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_msg  <= bus.m_text;
        m_busy <= 1'b1;
        m_age  <= 0;
      end
    end else if (m_age == N - 1) begin
      m_enc  <= ref_encode(m_msg);
      m_done <= 1'b1;
      m_age  <= N;
    end else if (m_age == N) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_age  <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", W'(bus.busy), W'(m_busy));
    check("cyc_done", W'(bus.done), W'(m_done));
    check("cyc_encoder", bus.encoder, m_enc);
  end

  task automatic run_block(input logic [N-1:0] msg, output int lat, output int bcyc);
    int  n;
    logic fin;
    @(negedge clk);
    bus.m_text = msg;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.m_text = ~msg;
    lat  = -1;
    bcyc = 0;
    n    = 0;
    fin  = 1'b0;
    while (n < 400 && !fin) begin
      if (bus.busy) bcyc++;
      if (bus.done) lat = n;
      if (!bus.busy) fin = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("block_finished", W'(fin), W'(1'b1));
  endtask

  logic [W-1:0] e;
  logic [N-1:0] msg;
  int lat, bcyc, dcnt, d0, d1;

  initial begin
    bus.start  = 1'b0;
    bus.m_text = '0;
    repeat (3) @(negedge clk);
    check("rst_encoder", bus.encoder, '0);
    check("rst_busy", W'(bus.busy), W'(1'b0));
    check("rst_done", W'(bus.done), W'(1'b0));
    #2 reset = 1'b1;

    e = ref_encode(N'(1));
    check("model_impulse", e, W'(14'h38F7));
    e = ref_encode('1);
    check("model_ones_lo", W'(e[13:0]), W'(14'h329B));
    check("model_ones_hi", W'(e[W-1:14]), W'({(W-14){1'b1}}));

    run_block('0, lat, bcyc);
    check("zero_latency", W'(lat), W'(N));
    check("zero_busy_cycles", W'(bcyc), W'(N + 1));
    check("zero_encoder", bus.encoder, '0);

    run_block(N'(1), lat, bcyc);
    check("impulse_encoder", bus.encoder, W'(14'h38F7));

    run_block('1, lat, bcyc);
    e = bus.encoder;
    check("ones_lo", W'(e[13:0]), W'(14'h329B));
    check("ones_hi", W'(e[W-1:14]), W'({(W-14){1'b1}}));

    repeat (5) @(negedge clk);
    check("encoder_hold", bus.encoder, ref_encode('1));

    // Start held high with m_text changing every cycle.
    dcnt = 0; d0 = -1; d1 = -1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.m_text = rnd_msg();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        if (dcnt == 0) d0 = i;
        if (dcnt == 1) d1 = i;
        dcnt++;
      end
      bus.m_text = rnd_msg();
    end
    bus.start = 1'b0;
    check("held_done_count", W'(dcnt), W'(2));
    check("held_done_first", W'(d0), W'(N));
    check("held_done_second", W'(d1), W'(2 * N + 2));
    for (int i = 0; i < 400 && bus.busy; i++) @(negedge clk);
    check("held_drained", W'(bus.busy), W'(1'b0));

    // Reset in the middle of a block.
    msg = rnd_msg();
    @(negedge clk);
    bus.m_text = msg;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_encoder", bus.encoder, '0);
    check("abort_busy", W'(bus.busy), W'(1'b0));
    check("abort_done", W'(bus.done), W'(1'b0));
    @(negedge clk);
    #2 reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort_no_done", W'(dcnt), W'(0));
    check("abort_encoder_kept", bus.encoder, '0);
    run_block(msg, lat, bcyc);
    check("after_abort_encoder", bus.encoder, ref_encode(msg));

    for (int b = 0; b < 30; b++) begin
      msg = rnd_msg();
      run_block(msg, lat, bcyc);
      check("rand_encoder", bus.encoder, ref_encode(msg));
      check("rand_viterbi", W'(viterbi(bus.encoder)), W'(msg));
      check("rand_latency", W'(lat), W'(N));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
